axi_lite_cfg_regfile: RTL and testbench
=======================================

Name: axi_lite_cfg_regfile

Overview:
AXI4-Lite subordinate that terminates the AXI4-Lite port produced by the Regbus-to-AXI4-Lite adapter and implements a small bank of configuration/status registers. It is the first stage downstream of that adapter, e.g. for accelerator control registers. The write and read paths are independent. Each path holds at most one outstanding response. Register contents are exported in parallel to the hardware.

Parameters:
NumRegs, 8, number of DataWidth-wide registers (>=1).
DataWidth, 32, AXI4-Lite data width and register width (32 or 64).
AddrWidth, 32, AXI4-Lite address width.
BaseAddr, 'h0, byte address of register 0; registers are at BaseAddr + i*(DataWidth/8).
ReadOnlyMask, '0, NumRegs bits; bit i=1 makes register i read-only (reads ro_data_i slice i).
ResetValue, '0, reset value applied to every writable register.
axi_lite_req_t, logic, AXI4-Lite request struct type (aw/w/ar channels with valids, b_ready, r_ready).
axi_lite_rsp_t, logic, AXI4-Lite response struct type (readies, b/r channels with valids).

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous, active-high reset.
axi_lite_req_i  in  axi_lite_req_t  AXI4-Lite request from the upstream adapter.
axi_lite_rsp_o  out  axi_lite_rsp_t  AXI4-Lite response.
reg_q_o  out  NumRegs*DataWidth  current register contents; slice i = register i (read-only slices echo ro_data_i).
reg_wr_o  out  NumRegs  one-cycle pulse: register i was written by a successful transaction.
ro_data_i  in  NumRegs*DataWidth  hardware status values for read-only registers; ignored for writable slices.

Behaviour:
- Reset (rst_i=1 at a clock edge) has the following effects:
  - writable registers get ResetValue;
  - AW/W holding slots are cleared;
  - b_valid=0, r_valid=0, reg_wr_o=0, r.data=0, b.resp=r.resp=OKAY;
  - in-flight transactions are dropped silently.
- aw_ready, w_ready and ar_ready are combinational from state only, never from valids. After reset they are all 1.
- Write path:
  - One-deep AW slot and one-deep W slot. aw_ready=!aw_full; w_ready=!w_full.
  - AW and W are accepted in any order or in the same cycle. Each slot captures on its own handshake.
  - Commit happens at the first edge where aw_full & w_full & !b_valid:
    - write applied per byte strobe;
    - both slots cleared;
    - b_valid set with resp;
    - reg_wr_o[idx] asserted for exactly the cycle after the commit edge (only on OKAY).
  - Minimum latency: AW+W handshake at edge k, commit and b_valid at edge k+1.
  - b_valid and b.resp are held stable until b_ready. b_valid clears at the handshake edge.
  - While b_valid=1, no commit occurs. Slots may still fill one beat each, then their readies stay low.
- Read path:
  - ar_ready=!r_valid. On an AR handshake at edge k, r_valid=1, r.data and r.resp are registered at edge k (1-cycle latency).
  - r_valid, r.data and r.resp are held stable until r_ready. A new AR is accepted only after the R handshake, so reads are not back-to-back (one read per 2 cycles minimum).
  - Writable registers return the stored value. Read-only registers return ro_data_i sampled at edge k.
- Decoding:
  - offset = addr - BaseAddr, computed modulo 2^AddrWidth.
  - Address is invalid if the low log2(DataWidth/8) bits of offset are nonzero, or if index >= NumRegs.
  - Invalid address: resp=SLVERR (2'b10). Writes have no effect and no pulse. Reads return data 0.
  - Write to a ReadOnlyMask register: SLVERR, no effect, no pulse.
  - A write with all strobes 0 to a valid writable register is OKAY: the register is unchanged but reg_wr_o still pulses.
- Simultaneous read and write to the same register at the same edge: the read returns the pre-write value.
- prot fields are ignored. Write and read responses are independent; no ordering between them is enforced.
- Unused AXI4-Lite response fields are driven 0.

Test Plan:
- Reset, then single write addr=0x8, data=0xDEADBEEF, strb=0xF, AW and W at the same edge k -> b_valid at k+1 with OKAY; reg_q_o slice 2 = 0xDEADBEEF; reg_wr_o=8'b0000_0100 for one cycle; read of 0x8 returns 0xDEADBEEF, OKAY, r_valid one cycle after the AR handshake.
- W beat 3 cycles before AW (addr 0x0, data 0x11223344, strb=0x3) with reg0=0xAABBCCDD -> w_ready drops after the W handshake; commit one edge after the AW handshake; reg0=0xAABB3344.
- b_ready held 0 for 5 cycles after b_valid, with a second AW+W presented -> b_valid and resp stable; second pair captured, then aw_ready=w_ready=0; second commit at the edge after the first B handshake.
- Write to 0x20 (index 8, NumRegs=8), write to 0x6 (misaligned), and read of 0x24 -> SLVERR on each; no reg_wr_o pulse; no register change; rdata=0.
- ReadOnlyMask=8'h80, ro_data_i slice 7=0x5A5A0001 -> read of 0x1C returns 0x5A5A0001 OKAY; write of 0x1C returns SLVERR; reg_q_o slice 7 follows ro_data_i.
- Read of 0x4 (old value 0x1) and write of 0x4 with data 0x2 committing at the same edge -> rdata=0x1, then reg1=0x2. Assert rst_i with a B response pending -> b_valid=0 after the reset edge; all registers at ResetValue.

Source files
------------

// File: rtl/axi_lite_cfg_regfile.sv
// axi_lite_cfg_regfile
// AXI4-Lite subordinate holding a small bank of configuration/status registers.
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous, active-high reset
//   axi_lite_req_i  AXI4-Lite request (aw/w/ar channels, valids, b_ready, r_ready)
//   axi_lite_rsp_o  AXI4-Lite response (readies, b/r channels, valids)
//   reg_q_o         register contents, slice i = register i (read-only slices echo ro_data_i)
//   reg_wr_o        one-cycle pulse per register after a successful write commit
//   ro_data_i       hardware status values shown by read-only registers
//
// Handshake rule: a beat transfers on the rising edge where valid and ready are
// both high. Readies here depend only on internal state, never on any valid.
// The write and read paths are independent; each holds at most one response.

package axi_lite_cfg_regfile_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } rsp_t;
endpackage

module axi_lite_cfg_regfile #(
    parameter int unsigned          NumRegs      = 8,
    parameter int unsigned          DataWidth    = 32,
    parameter int unsigned          AddrWidth    = 32,
    parameter logic [AddrWidth-1:0] BaseAddr     = '0,
    parameter logic [NumRegs-1:0]   ReadOnlyMask = '0,
    parameter logic [DataWidth-1:0] ResetValue   = '0,
    parameter type axi_lite_req_t = axi_lite_cfg_regfile_pkg::req_t,
    parameter type axi_lite_rsp_t = axi_lite_cfg_regfile_pkg::rsp_t
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  axi_lite_req_t                  axi_lite_req_i,
    output axi_lite_rsp_t                  axi_lite_rsp_o,
    output logic [NumRegs*DataWidth-1:0]   reg_q_o,
    output logic [NumRegs-1:0]             reg_wr_o,
    input  logic [NumRegs*DataWidth-1:0]   ro_data_i
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned AddrLsb   = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = (NumRegs > 1) ? $clog2(NumRegs) : 1;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    // Write holding slots and response
    logic                 aw_full;
    logic [AddrWidth-1:0] aw_addr;
    logic                 w_full;
    logic [DataWidth-1:0] w_data;
    logic [StrbWidth-1:0] w_strb;
    logic                 b_valid;
    logic [1:0]           b_resp;

    // Read response
    logic                 r_valid;
    logic [DataWidth-1:0] r_data;
    logic [1:0]           r_resp;

    logic [DataWidth-1:0] regs     [NumRegs];
    logic [DataWidth-1:0] reg_view [NumRegs];
    logic [NumRegs-1:0]   reg_wr;

    logic aw_hs, w_hs, ar_hs, commit;
    assign aw_hs  = axi_lite_req_i.aw_valid & ~aw_full;
    assign w_hs   = axi_lite_req_i.w_valid & ~w_full;
    assign ar_hs  = axi_lite_req_i.ar_valid & ~r_valid;
    // A pending B response blocks the commit; slots may still fill meanwhile.
    assign commit = aw_full & w_full & ~b_valid;

    // Decode: offset wraps modulo 2^AddrWidth, must be word aligned and in range.
    logic [AddrWidth-1:0] wr_off, rd_off;
    logic                 wr_hit, wr_ok, rd_hit;
    logic [IdxWidth-1:0]  wr_idx, rd_idx;

    assign wr_off = aw_addr - BaseAddr;
    assign rd_off = axi_lite_req_i.ar.addr - BaseAddr;
    assign wr_hit = (wr_off[AddrLsb-1:0] == '0) && ((wr_off >> AddrLsb) < AddrWidth'(NumRegs));
    assign rd_hit = (rd_off[AddrLsb-1:0] == '0) && ((rd_off >> AddrLsb) < AddrWidth'(NumRegs));
    assign wr_idx = wr_off[AddrLsb +: IdxWidth];
    assign rd_idx = rd_off[AddrLsb +: IdxWidth];
    assign wr_ok  = wr_hit && !ReadOnlyMask[wr_idx];

    // What software and hardware see: stored value, or live status for read-only slots.
    for (genvar i = 0; i < NumRegs; i++) begin : g_view
        assign reg_view[i] = ReadOnlyMask[i] ? ro_data_i[i*DataWidth +: DataWidth] : regs[i];
        assign reg_q_o[i*DataWidth +: DataWidth] = reg_view[i];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_full <= 1'b0;
            aw_addr <= '0;
            w_full  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            b_valid <= 1'b0;
            b_resp  <= RespOkay;
            reg_wr  <= '0;
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= ResetValue;
            end
        end else begin
            reg_wr <= '0;
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= axi_lite_req_i.aw.addr;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= axi_lite_req_i.w.data;
                w_strb <= axi_lite_req_i.w.strb;
            end
            if (b_valid && axi_lite_req_i.b_ready) begin
                b_valid <= 1'b0;
            end
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                b_valid <= 1'b1;
                b_resp  <= wr_ok ? RespOkay : RespSlvErr;
                if (wr_ok) begin
                    // An all-zero strobe still counts as a write and pulses.
                    reg_wr[wr_idx] <= 1'b1;
                    for (int b = 0; b < StrbWidth; b++) begin
                        if (w_strb[b]) begin
                            regs[wr_idx][8*b +: 8] <= w_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // The read samples reg_view before any same-edge write lands, so a
    // colliding read returns the pre-write value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_resp  <= RespOkay;
        end else if (ar_hs) begin
            r_valid <= 1'b1;
            r_data  <= rd_hit ? reg_view[rd_idx] : '0;
            r_resp  <= rd_hit ? RespOkay : RespSlvErr;
        end else if (r_valid && axi_lite_req_i.r_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign reg_wr_o = reg_wr;

    always_comb begin
        axi_lite_rsp_o          = '0;
        axi_lite_rsp_o.aw_ready = ~aw_full;
        axi_lite_rsp_o.w_ready  = ~w_full;
        axi_lite_rsp_o.b_valid  = b_valid;
        axi_lite_rsp_o.b.resp   = b_resp;
        axi_lite_rsp_o.ar_ready = ~r_valid;
        axi_lite_rsp_o.r_valid  = r_valid;
        axi_lite_rsp_o.r.data   = r_data;
        axi_lite_rsp_o.r.resp   = r_resp;
    end

    // Protection attributes carry no meaning for this register bank.
    logic unused_prot;
    assign unused_prot = ^{axi_lite_req_i.aw.prot, axi_lite_req_i.ar.prot};

endmodule

// File: tb/tb_axi_lite_cfg_regfile.sv
// Testbench for axi_lite_cfg_regfile: directed scenarios plus randomized
// traffic compared against a register-array reference model.
module tb_axi_lite_cfg_regfile;
    import axi_lite_cfg_regfile_pkg::*;

    localparam int          NR      = 8;
    localparam logic [31:0] RST_VAL = 32'h0BAD_F00D;
    localparam logic [7:0]  RO_MASK = 8'h80;

    logic           clk;
    logic           rst;
    req_t           req;
    rsp_t           rsp;
    logic [255:0]   reg_q;
    logic [7:0]     reg_wr;
    logic [255:0]   ro_data;

    int tests;
    int failed;
    logic [31:0] model [NR];
    logic [33:0] exp_q [$];

    axi_lite_cfg_regfile #(
        .NumRegs(NR),
        .DataWidth(32),
        .AddrWidth(32),
        .BaseAddr(32'h0),
        .ReadOnlyMask(RO_MASK),
        .ResetValue(RST_VAL),
        .axi_lite_req_t(req_t),
        .axi_lite_rsp_t(rsp_t)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .axi_lite_req_i(req),
        .axi_lite_rsp_o(rsp),
        .reg_q_o(reg_q),
        .reg_wr_o(reg_wr),
        .ro_data_i(ro_data)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] q_slice(input int i);
        return reg_q[i*32 +: 32];
    endfunction

    function automatic logic [31:0] ro_slice(input int i);
        return ro_data[i*32 +: 32];
    endfunction

    function automatic bit addr_valid(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < 32'(NR));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) model[i] = RST_VAL;
    endfunction

    function automatic logic [31:0] model_view(input int i);
        return RO_MASK[i] ? ro_slice(i) : model[i];
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s, output logic [7:0] pulse);
        int idx;
        pulse = '0;
        if (!addr_valid(a)) return 2'b10;
        idx = int'(a >> 2);
        if (RO_MASK[idx]) return 2'b10;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        end
        pulse[idx] = 1'b1;
        return 2'b00;
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] a);
        if (!addr_valid(a)) return {2'b10, 32'h0};
        return {2'b00, model_view(int'(a >> 2))};
    endfunction

    // ---------------- driver tasks ----------------
    // Presents AW and/or W until each has handshaken; returns at the
    // negedge following the last handshake edge.
    task automatic push(input bit do_aw, input bit do_w, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
        bit aw_p, w_p, aw_h, w_h;
        int n;
        aw_p = do_aw;
        w_p  = do_w;
        req.aw.addr  = addr;
        req.aw.prot  = 3'($urandom);
        req.w.data   = data;
        req.w.strb   = strb;
        req.aw_valid = aw_p;
        req.w_valid  = w_p;
        n = 0;
        while ((aw_p || w_p) && n < 20) begin
            aw_h = aw_p && rsp.aw_ready;
            w_h  = w_p && rsp.w_ready;
            @(negedge clk);
            if (aw_h) begin aw_p = 1'b0; req.aw_valid = 1'b0; end
            if (w_h)  begin w_p  = 1'b0; req.w_valid  = 1'b0; end
            n++;
        end
        if (aw_p || w_p) begin
            tests++; failed++;
            $display("FAIL push_timeout addr=%h aw_pending=%0d w_pending=%0d", addr, aw_p, w_p);
            req.aw_valid = 1'b0;
            req.w_valid  = 1'b0;
        end
    endtask

    // Waits for B, reports the negedges waited, the response and the
    // reg_wr_o value seen in the first b_valid cycle, then acknowledges.
    task automatic wait_b(output logic [1:0] resp, output int lat, output logic [7:0] pulse);
        lat = 0;
        resp = 2'bxx;
        pulse = 'x;
        while (!rsp.b_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp.b_valid) begin
            tests++; failed++;
            $display("FAIL b_timeout got=no_b_valid exp=b_valid");
        end else begin
            resp  = rsp.b.resp;
            pulse = reg_wr;
            req.b_ready = 1'b1;
            @(negedge clk);
            req.b_ready = 1'b0;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        bit hs;
        hs = 1'b0;
        req.ar.addr  = addr;
        req.ar.prot  = 3'($urandom);
        req.ar_valid = 1'b1;
        for (int n = 0; n < 20 && !hs; n++) begin
            hs = rsp.ar_ready;
            @(negedge clk);
        end
        req.ar_valid = 1'b0;
        lat = 0;
        data = 'x;
        resp = 2'bxx;
        if (!hs) begin
            tests++; failed++;
            $display("FAIL ar_timeout addr=%h", addr);
            return;
        end
        while (!rsp.r_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp.r_valid) begin
            tests++; failed++;
            $display("FAIL r_timeout addr=%h", addr);
            return;
        end
        data = rsp.r.data;
        resp = rsp.r.resp;
        req.r_ready = 1'b1;
        @(negedge clk);
        req.r_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic check_all_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            tests++;
            if (q_slice(i) !== model_view(i)) begin
                failed++;
                $display("FAIL %s reg%0d got=%h exp=%h", tag, i, q_slice(i), model_view(i));
            end
        end
    endtask

    task automatic test_reset();
        req = '0;
        ro_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        ro_data[7*32 +: 32] = 32'h5A5A_0001;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        tests++;
        if ({rsp.aw_ready, rsp.w_ready, rsp.ar_ready} !== 3'b111) begin
            failed++;
            $display("FAIL reset_readies got=%b exp=111", {rsp.aw_ready, rsp.w_ready, rsp.ar_ready});
        end
        tests++;
        if ({rsp.b_valid, rsp.r_valid, reg_wr, rsp.r.data, rsp.b.resp, rsp.r.resp} !== '0) begin
            failed++;
            $display("FAIL reset_outputs got b_valid=%b r_valid=%b reg_wr=%h rdata=%h exp all zero",
                     rsp.b_valid, rsp.r_valid, reg_wr, rsp.r.data);
        end
        check_all_regs("reset_value");
    endtask

    task automatic test_single_write();
        logic [1:0] resp; int lat; logic [7:0] pulse; logic [7:0] pe; logic [31:0] d;
        void'(model_write(32'h8, 32'hDEAD_BEEF, 4'hF, pe));
        push(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF);
        tests++;
        if (rsp.b_valid !== 1'b0) begin
            failed++;
            $display("FAIL single_b_early got=%b exp=0", rsp.b_valid);
        end
        wait_b(resp, lat, pulse);
        tests++;
        if (lat != 1 || resp !== 2'b00 || pulse !== 8'b0000_0100) begin
            failed++;
            $display("FAIL single_b got lat=%0d resp=%b pulse=%b exp lat=1 resp=00 pulse=00000100",
                     lat, resp, pulse);
        end
        tests++;
        if (reg_wr !== 8'h00) begin
            failed++;
            $display("FAIL single_pulse_len got=%b exp=00000000", reg_wr);
        end
        tests++;
        if (q_slice(2) !== 32'hDEAD_BEEF) begin
            failed++;
            $display("FAIL single_reg2 got=%h exp=deadbeef", q_slice(2));
        end
        do_read(32'h8, d, resp, lat);
        tests++;
        if (d !== 32'hDEAD_BEEF || resp !== 2'b00 || lat != 0) begin
            failed++;
            $display("FAIL single_read got data=%h resp=%b lat=%0d exp data=deadbeef resp=00 lat=0",
                     d, resp, lat);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; int lat; logic [7:0] pulse; logic [7:0] pe;
        void'(model_write(32'h0, 32'hAABB_CCDD, 4'hF, pe));
        push(1'b1, 1'b1, 32'h0, 32'hAABB_CCDD, 4'hF);
        wait_b(resp, lat, pulse);
        push(1'b0, 1'b1, 32'h0, 32'h1122_3344, 4'h3);
        tests++;
        if (rsp.w_ready !== 1'b0 || rsp.aw_ready !== 1'b1) begin
            failed++;
            $display("FAIL wfirst_readies got w_ready=%b aw_ready=%b exp w_ready=0 aw_ready=1",
                     rsp.w_ready, rsp.aw_ready);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (rsp.b_valid !== 1'b0 || rsp.w_ready !== 1'b0) begin
            failed++;
            $display("FAIL wfirst_wait got b_valid=%b w_ready=%b exp 0 0", rsp.b_valid, rsp.w_ready);
        end
        push(1'b1, 1'b0, 32'h0, 32'h1122_3344, 4'h3);
        wait_b(resp, lat, pulse);
        void'(model_write(32'h0, 32'h1122_3344, 4'h3, pe));
        tests++;
        if (lat != 1 || resp !== 2'b00 || pulse !== 8'h01 || q_slice(0) !== 32'hAABB_3344) begin
            failed++;
            $display("FAIL wfirst_commit got lat=%0d resp=%b pulse=%h reg0=%h exp 1 00 01 aabb3344",
                     lat, resp, pulse, q_slice(0));
        end
    endtask

    task automatic test_b_backpressure();
        logic [7:0] pe;
        logic [31:0] old5;
        void'(model_write(32'h10, 32'h0101_0101, 4'hF, pe));
        push(1'b1, 1'b1, 32'h10, 32'h0101_0101, 4'hF);
        @(negedge clk);
        tests++;
        if (rsp.b_valid !== 1'b1 || reg_wr !== 8'h10) begin
            failed++;
            $display("FAIL bp_first got b_valid=%b reg_wr=%h exp 1 10", rsp.b_valid, reg_wr);
        end
        old5 = model[5];
        req.aw.addr = 32'h14; req.w.data = 32'h0202_0202; req.w.strb = 4'hF;
        req.aw_valid = 1'b1; req.w_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin req.aw_valid = 1'b0; req.w_valid = 1'b0; end
            tests++;
            if (rsp.b_valid !== 1'b1 || rsp.b.resp !== 2'b00 || rsp.aw_ready !== 1'b0 || rsp.w_ready !== 1'b0) begin
                failed++;
                $display("FAIL bp_hold cyc=%0d got b_valid=%b resp=%b aw_ready=%b w_ready=%b exp 1 00 0 0",
                         i, rsp.b_valid, rsp.b.resp, rsp.aw_ready, rsp.w_ready);
            end
        end
        req.b_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
        tests++;
        if (rsp.b_valid !== 1'b0 || q_slice(5) !== old5) begin
            failed++;
            $display("FAIL bp_ack got b_valid=%b reg5=%h exp 0 %h", rsp.b_valid, q_slice(5), old5);
        end
        void'(model_write(32'h14, 32'h0202_0202, 4'hF, pe));
        @(negedge clk);
        tests++;
        if (rsp.b_valid !== 1'b1 || q_slice(5) !== 32'h0202_0202 || reg_wr !== pe) begin
            failed++;
            $display("FAIL bp_second got b_valid=%b reg5=%h reg_wr=%h exp 1 02020202 %h",
                     rsp.b_valid, q_slice(5), reg_wr, pe);
        end
        req.b_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
    endtask

    task automatic test_decode_errors();
        logic [1:0] resp; int lat; logic [7:0] pulse; logic [7:0] pe; logic [31:0] d;
        logic [31:0] addrs [2];
        addrs[0] = 32'h20;
        addrs[1] = 32'h6;
        for (int k = 0; k < 2; k++) begin
            d = $urandom;
            tests++;
            if (model_write(addrs[k], d, 4'hF, pe) !== 2'b10) begin
                failed++;
                $display("FAIL model_decode addr=%h", addrs[k]);
            end
            push(1'b1, 1'b1, addrs[k], d, 4'hF);
            wait_b(resp, lat, pulse);
            tests++;
            if (resp !== 2'b10 || pulse !== 8'h00) begin
                failed++;
                $display("FAIL bad_write addr=%h got resp=%b pulse=%h exp 10 00", addrs[k], resp, pulse);
            end
        end
        check_all_regs("bad_write_nochange");
        do_read(32'h24, d, resp, lat);
        tests++;
        if (resp !== 2'b10 || d !== 32'h0) begin
            failed++;
            $display("FAIL bad_read got resp=%b data=%h exp 10 00000000", resp, d);
        end
    endtask

    task automatic test_read_only();
        logic [1:0] resp; int lat; logic [7:0] pulse; logic [31:0] d;
        do_read(32'h1C, d, resp, lat);
        tests++;
        if (d !== 32'h5A5A_0001 || resp !== 2'b00) begin
            failed++;
            $display("FAIL ro_read got data=%h resp=%b exp 5a5a0001 00", d, resp);
        end
        push(1'b1, 1'b1, 32'h1C, 32'hFFFF_FFFF, 4'hF);
        wait_b(resp, lat, pulse);
        tests++;
        if (resp !== 2'b10 || pulse !== 8'h00 || q_slice(7) !== 32'h5A5A_0001) begin
            failed++;
            $display("FAIL ro_write got resp=%b pulse=%h reg7=%h exp 10 00 5a5a0001", resp, pulse, q_slice(7));
        end
        ro_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        check_all_regs("ro_follow");
    endtask

    task automatic test_rw_collision();
        logic [1:0] resp; int lat; logic [7:0] pulse; logic [7:0] pe; logic [33:0] e;
        void'(model_write(32'h4, 32'h1, 4'hF, pe));
        push(1'b1, 1'b1, 32'h4, 32'h1, 4'hF);
        wait_b(resp, lat, pulse);
        e = model_read(32'h4);
        req.aw.addr = 32'h4; req.w.data = 32'h2; req.w.strb = 4'hF;
        req.aw_valid = 1'b1; req.w_valid = 1'b1;
        @(negedge clk);
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        req.ar.addr = 32'h4; req.ar_valid = 1'b1;
        @(negedge clk);
        req.ar_valid = 1'b0;
        void'(model_write(32'h4, 32'h2, 4'hF, pe));
        tests++;
        if (rsp.r_valid !== 1'b1 || {rsp.r.resp, rsp.r.data} !== e || rsp.b_valid !== 1'b1) begin
            failed++;
            $display("FAIL collide_read got r_valid=%b resp=%b data=%h b_valid=%b exp 1 00 00000001 1",
                     rsp.r_valid, rsp.r.resp, rsp.r.data, rsp.b_valid);
        end
        req.r_ready = 1'b1; req.b_ready = 1'b1;
        @(negedge clk);
        req.r_ready = 1'b0; req.b_ready = 1'b0;
        tests++;
        if (rsp.r_valid !== 1'b0 || q_slice(1) !== 32'h2) begin
            failed++;
            $display("FAIL collide_after got r_valid=%b reg1=%h exp 0 00000002", rsp.r_valid, q_slice(1));
        end
    endtask

    task automatic test_random();
        logic [1:0] resp; int lat; logic [7:0] pulse; logic [7:0] pe; logic [31:0] d;
        logic [31:0] addr, data; logic [3:0] strb; logic [1:0] re; logic [33:0] e, got;
        int mode;
        for (int it = 0; it < 150; it++) begin
            addr = 32'($urandom_range(0, 9)) * 4;
            if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 0) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                re = model_write(addr, data, strb, pe);
                exp_q.push_back({re, 24'h0, pe});
                mode = $urandom_range(0, 2);
                if (mode == 0) push(1'b1, 1'b1, addr, data, strb);
                else if (mode == 1) begin push(1'b1, 1'b0, addr, data, strb); push(1'b0, 1'b1, addr, data, strb); end
                else begin push(1'b0, 1'b1, addr, data, strb); push(1'b1, 1'b0, addr, data, strb); end
                wait_b(resp, lat, pulse);
                got = {resp, 24'h0, pulse};
                e = exp_q.pop_front();
                tests++;
                if (got !== e || lat != 1) begin
                    failed++;
                    $display("FAIL rand_write it=%0d addr=%h got=%h lat=%0d exp=%h lat=1", it, addr, got, lat, e);
                end
            end else begin
                ro_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                exp_q.push_back(model_read(addr));
                do_read(addr, d, resp, lat);
                got = {resp, d};
                e = exp_q.pop_front();
                tests++;
                if (got !== e || lat != 0) begin
                    failed++;
                    $display("FAIL rand_read it=%0d addr=%h got=%h lat=%0d exp=%h lat=0", it, addr, got, lat, e);
                end
            end
        end
        check_all_regs("rand_final");
    endtask

    task automatic test_reset_pending();
        logic [1:0] resp; int lat; logic [7:0] pulse; logic [7:0] pe;
        ro_data[7*32 +: 32] = 32'h5A5A_0001;
        push(1'b1, 1'b1, 32'h0, 32'h1234_5678, 4'hF);
        @(negedge clk);
        push(1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        req.ar.addr = 32'h1C; req.ar_valid = 1'b1;
        @(negedge clk);
        req.ar_valid = 1'b0;
        tests++;
        if (rsp.b_valid !== 1'b1 || rsp.r_valid !== 1'b1) begin
            failed++;
            $display("FAIL pend_setup got b_valid=%b r_valid=%b exp 1 1", rsp.b_valid, rsp.r_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tests++;
        if ({rsp.b_valid, rsp.r_valid, reg_wr, rsp.r.data, rsp.b.resp} !== '0 ||
            {rsp.aw_ready, rsp.w_ready, rsp.ar_ready} !== 3'b111) begin
            failed++;
            $display("FAIL pend_reset got b_valid=%b r_valid=%b reg_wr=%h rdata=%h readies=%b exp 0 0 00 0 111",
                     rsp.b_valid, rsp.r_valid, reg_wr, rsp.r.data, {rsp.aw_ready, rsp.w_ready, rsp.ar_ready});
        end
        check_all_regs("pend_reset_regs");
        void'(model_write(32'hC, 32'hCAFE_0003, 4'hF, pe));
        push(1'b1, 1'b1, 32'hC, 32'hCAFE_0003, 4'hF);
        wait_b(resp, lat, pulse);
        tests++;
        if (lat != 1 || resp !== 2'b00 || pulse !== pe || q_slice(3) !== 32'hCAFE_0003) begin
            failed++;
            $display("FAIL post_reset_write got lat=%0d resp=%b pulse=%h reg3=%h exp 1 00 %h cafe0003",
                     lat, resp, pulse, q_slice(3), pe);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests = 0;
        failed = 0;
        rst = 1'b1;
        req = '0;
        ro_data = '0;
        test_reset();
        test_single_write();
        test_w_before_aw();
        test_b_backpressure();
        test_decode_errors();
        test_read_only();
        test_rw_collision();
        test_random();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
